spi_slave_sync: RTL and testbench

Parametrised SPI slave that oversamples the SPI pins in the system clock domain and provides full-duplex word transfer with a simple load/valid handshake toward fabric logic. It replaces the receive-only, sclk-clocked SPI front end feeding the board LEDs. Word width, SPI mode (CPOL/CPHA) and synchroniser depth are configurable. MISO is driven, so replies can be returned to the master.

---
 rtl/spi_slave_sync.sv | 185 ++++++++++++++++++
 tb/tb_spi_slave_sync.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_sync.sv
// SPI slave oversampled in the clk domain, full duplex, MSB first.
// Load/valid handshake toward fabric; CPOL/CPHA selectable.
module spi_slave_sync #(
    parameter int DATA_W      = 16,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              frame_err
);

    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
    localparam bit SAMPLE_RISE = (CPOL == CPHA);
    localparam bit LOAD_AT_CS = (CPHA == 0);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
    logic sclk_h, cs_h;
    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic sample_edge, shift_edge;
    logic start, stop, do_sample, do_shift, consume;

    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] tx_buf;
    logic [DATA_W-1:0] tx_next;

    // Bring the asynchronous SPI pins into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q <= '0;
            cs_q   <= '0;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], cs};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
        end
    end

    // One history flop each on sclk and cs for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_h <= 1'b0;
            cs_h   <= 1'b0;
        end else begin
            sclk_h <= sclk_s;
            cs_h   <= cs_s;
        end
    end

    assign sclk_s = sclk_q[SYNC_STAGES-1];
    assign cs_s   = cs_q[SYNC_STAGES-1];
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_h;
    assign sclk_fall = ~sclk_s & sclk_h;
    assign cs_fall   = ~cs_s & cs_h;
    assign cs_rise   = cs_s & ~cs_h;

    assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
    assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Frame sequencing; sclk edges only count inside an active frame.
    always_comb begin
        state_n   = state;
        start     = 1'b0;
        stop      = 1'b0;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_n = ACTIVE;
                    start   = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_n = IDLE;
                    stop    = 1'b1;
                end else begin
                    do_sample = sample_edge;
                    do_shift  = shift_edge;
                end
            end
        endcase
    end

    assign consume = (start & LOAD_AT_CS) | (do_shift & (bit_cnt == '0));
    assign tx_next = tx_ready ? '0 : tx_buf;

    // Receive shifter, bit counter and word/frame status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            rx_sr     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (start) begin
                bit_cnt <= '0;
                rx_sr   <= '0;
            end
            if (stop && bit_cnt != '0) begin
                frame_err <= 1'b1;
            end
            if (do_sample) begin
                rx_sr <= {rx_sr[DATA_W-2:0], mosi_s};
                if (bit_cnt == LAST) begin
                    bit_cnt  <= '0;
                    rx_data  <= {rx_sr[DATA_W-2:0], mosi_s};
                    rx_valid <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    // Transmit shifter: reload at word start, else shift left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sr <= '0;
        end else if (start && LOAD_AT_CS) begin
            tx_sr <= tx_next;
        end else if (do_shift) begin
            if (bit_cnt == '0) begin
                tx_sr <= tx_next;
            end else begin
                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end
        end
    end

    // Single-entry tx buffer; a load is honoured only while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_buf   <= '0;
            tx_ready <= 1'b1;
        end else if (tx_load && tx_ready) begin
            tx_buf   <= tx_data;
            tx_ready <= 1'b0;
        end else if (consume) begin
            tx_ready <= 1'b1;
        end
    end

    assign busy = (state == ACTIVE);
    assign miso = busy & tx_sr[DATA_W-1];

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: one instance per SPI mode, bit-banged
// master, behavioural tx-buffer model and rx/frame_err monitors.
module tb_spi_slave_sync;

    localparam int H = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  sclk, cs, mosi, miso, tx_load, tx_ready;
    logic [3:0]  rx_valid, busy, frame_err;
    logic [15:0] tx_data [4];
    logic [15:0] rx_data [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_sync #(
            .DATA_W(16),
            .CPOL(g / 2),
            .CPHA(g % 2),
            .SYNC_STAGES(2)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .sclk(sclk[g]),
            .cs(cs[g]),
            .mosi(mosi[g]),
            .miso(miso[g]),
            .tx_data(tx_data[g]),
            .tx_load(tx_load[g]),
            .tx_ready(tx_ready[g]),
            .rx_data(rx_data[g]),
            .rx_valid(rx_valid[g]),
            .busy(busy[g]),
            .frame_err(frame_err[g])
        );
    end

    int tests = 0;
    int fails = 0;

    int rxv_cnt [4] = '{default: 0};
    int ferr_cnt [4] = '{default: 0};
    logic [15:0] rx_hist [4][16];

    // Pulse monitors, sampled away from the active edge.
    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (rx_valid[m]) begin
                rx_hist[m][rxv_cnt[m] % 16] <= rx_data[m];
                rxv_cnt[m] <= rxv_cnt[m] + 1;
            end
            if (frame_err[m]) begin
                ferr_cnt[m] <= ferr_cnt[m] + 1;
            end
        end
    end

    logic [15:0] mbuf [4];
    bit          mfull [4] = '{default: 1'b0};
    logic [15:0] mw [4];
    logic [15:0] ew [4];
    logic [15:0] got [4];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void mload(input int m, input logic [15:0] v);
        if (!mfull[m]) begin
            mbuf[m]  = v;
            mfull[m] = 1'b1;
        end
    endfunction

    function automatic logic [15:0] mtake(input int m);
        logic [15:0] r;
        r = mfull[m] ? mbuf[m] : 16'h0000;
        mfull[m] = 1'b0;
        return r;
    endfunction

    // Expected miso words: one buffer take per word start; CPHA=0
    // also takes once more on the final shift edge of a full frame.
    task automatic plan(input int m, input int n, input bit full);
        logic [15:0] d;
        for (int w = 0; w < n; w++) ew[w] = mtake(m);
        if (m % 2 == 0 && full) d = mtake(m);
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int m, input logic [15:0] v);
        tx_data[m] = v;
        tx_load[m] = 1'b1;
        clks(1);
        tx_load[m] = 1'b0;
    endtask

    task automatic xfer(input int m, input int n, input int lastbits);
        bit pol, pha;
        int nb;
        pol = (m / 2) == 1;
        pha = (m % 2) == 1;
        cs[m] = 1'b0;
        clks(8);
        if (!pha) chk("miso_msb_before_edge", miso[m], ew[0][15]);
        for (int w = 0; w < n; w++) begin
            nb = (w == n - 1) ? lastbits : 16;
            got[w] = '0;
            for (int b = 0; b < nb; b++) begin
                if (!pha) begin
                    mosi[m] = mw[w][15-b];
                    clks(H);
                    sclk[m] = ~pol;
                    got[w] = {got[w][14:0], miso[m]};
                    clks(H);
                    sclk[m] = pol;
                end else begin
                    sclk[m] = ~pol;
                    mosi[m] = mw[w][15-b];
                    clks(H);
                    sclk[m] = pol;
                    got[w] = {got[w][14:0], miso[m]};
                    clks(H);
                end
            end
        end
        clks(8);
        cs[m] = 1'b1;
        clks(8);
    endtask

    task automatic run(input int m, input int n, input int lastbits);
        int c0, f0, full;
        logic [15:0] rxd0;
        c0 = rxv_cnt[m];
        f0 = ferr_cnt[m];
        rxd0 = rx_data[m];
        xfer(m, n, lastbits);
        full = (lastbits == 16) ? n : n - 1;
        chk("rx_valid_count", rxv_cnt[m] - c0, full);
        for (int w = 0; w < full; w++) begin
            chk("rx_word", rx_hist[m][(c0 + w) % 16], mw[w]);
            chk("miso_word", got[w], ew[w]);
        end
        chk("frame_err_count", ferr_cnt[m] - f0, (lastbits != 16) ? 1 : 0);
        if (lastbits != 16) chk("rx_data_kept", rx_data[m], rxd0);
    endtask

    task automatic reset_chk();
        for (int m = 0; m < 4; m++) begin
            chk("rst_miso", miso[m], 0);
            chk("rst_tx_ready", tx_ready[m], 1);
            chk("rst_rx_data", rx_data[m], 0);
            chk("rst_rx_valid", rx_valid[m], 0);
            chk("rst_busy", busy[m], 0);
            chk("rst_frame_err", frame_err[m], 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n;
        logic [15:0] d;
        for (int m = 0; m < 4; m++) begin
            sclk[m] = (m / 2) == 1;
            cs[m] = 1'b1;
            mosi[m] = 1'b0;
            tx_load[m] = 1'b0;
            tx_data[m] = '0;
        end
        clks(3);
        reset_chk();
        rst = 1'b0;
        clks(6);

        load(0, 16'hA5C3);
        mload(0, 16'hA5C3);
        chk("tx_ready_after_load", tx_ready[0], 0);
        mw[0] = 16'h1234;
        plan(0, 1, 1'b1);
        run(0, 1, 16);
        chk("tx_ready_after_frame", tx_ready[0], 1);

        for (int m = 0; m < 4; m++) begin
            load(m, 16'h0F0F);
            mload(m, 16'h0F0F);
            mw[0] = 16'hBEEF;
            plan(m, 1, 1'b1);
            run(m, 1, 16);
        end

        load(0, 16'h1111);
        mload(0, 16'h1111);
        mw[0] = 16'h0001;
        mw[1] = 16'hFFFF;
        mw[2] = 16'h8000;
        ew[0] = mtake(0);
        mload(0, 16'h2222);
        ew[1] = mtake(0);
        ew[2] = mtake(0);
        d = mtake(0);
        fork
            run(0, 3, 16);
            begin
                k = 0;
                while (!(busy[0] && tx_ready[0]) && k < 2000) begin
                    clks(1);
                    k++;
                end
                chk("b2b_reload_window", tx_ready[0], 1);
                load(0, 16'h2222);
            end
        join

        for (int m = 0; m < 2; m++) begin
            mw[0] = 16'($urandom);
            plan(m, 1, 1'b0);
            run(m, 1, 7);
            d = 16'($urandom);
            load(m, d);
            mload(m, d);
            mw[0] = 16'($urandom);
            plan(m, 1, 1'b1);
            run(m, 1, 16);
        end

        load(1, 16'h1357);
        mload(1, 16'h1357);
        chk("tx_ready_full", tx_ready[1], 0);
        load(1, 16'h2468);
        mload(1, 16'h2468);
        mw[0] = 16'hC0DE;
        plan(1, 1, 1'b1);
        run(1, 1, 16);

        for (int r = 0; r < 3; r++) begin
            for (int m = 0; m < 4; m++) begin
                n = 1 + int'($urandom_range(1, 0));
                d = 16'($urandom);
                load(m, d);
                mload(m, d);
                for (int w = 0; w < n; w++) mw[w] = 16'($urandom);
                plan(m, n, 1'b1);
                run(m, n, 16);
            end
        end

        load(3, 16'h7777);
        k = rxv_cnt[0];
        n = ferr_cnt[0];
        cs[0] = 1'b0;
        clks(8);
        for (int b = 0; b < 5; b++) begin
            mosi[0] = 1'b1;
            clks(H);
            sclk[0] = 1'b1;
            clks(H);
            sclk[0] = 1'b0;
        end
        clks(3);
        rst = 1'b1;
        clks(3);
        reset_chk();
        for (int m = 0; m < 4; m++) mfull[m] = 1'b0;
        rst = 1'b0;
        clks(10);
        chk("idle_cs_low_after_rst", busy[0], 0);
        cs[0] = 1'b1;
        clks(8);
        chk("rst_no_rx_valid", rxv_cnt[0] - k, 0);
        chk("rst_no_frame_err", ferr_cnt[0] - n, 0);
        d = 16'($urandom);
        load(0, d);
        mload(0, d);
        mw[0] = 16'($urandom);
        plan(0, 1, 1'b1);
        run(0, 1, 16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
